// File: rtl/input_conditioner_if.sv
// Configuration and status bundle between the timer register block and input_conditioner.
// The master side drives configuration and raw inputs; the slave side is the conditioner.
interface input_conditioner_if #(
    parameter int NCH    = 15,
    parameter int FILT_W = 4,
    parameter int ECNT_W = 8
);
    logic              en_i;
    logic              clear_i;
    logic [NCH:1]      input_i;
    logic [FILT_W-1:0] filt_len_i;
    logic [3:0]        ch_sel_i;
    logic [1:0]        edge_sel_i;
    logic              sw_trigger_i;
    logic [NCH:1]      filt_o;
    logic              level_o;
    logic              trig_o;
    logic [ECNT_W-1:0] evt_cnt_o;

    modport master (
        output en_i, clear_i, input_i, filt_len_i, ch_sel_i, edge_sel_i, sw_trigger_i,
        input  filt_o, level_o, trig_o, evt_cnt_o
    );

    modport slave (
        input  en_i, clear_i, input_i, filt_len_i, ch_sel_i, edge_sel_i, sw_trigger_i,
        output filt_o, level_o, trig_o, evt_cnt_o
    );
endinterface

// File: rtl/input_conditioner.sv
// Trigger front end: per-channel sync + glitch filter, source mux, edge/level
// qualification into a single-cycle trigger, and a saturating event counter.
module input_conditioner #(
    parameter int NCH    = 15,
    parameter int FILT_W = 4,
    parameter int ECNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input_conditioner_if.slave    bus
);
    typedef enum logic [1:0] {
        EDGE_RISE  = 2'b00,
        EDGE_FALL  = 2'b01,
        EDGE_BOTH  = 2'b10,
        LEVEL_HIGH = 2'b11
    } edge_mode_t;

    logic [NCH:1]      sync1;
    logic [NCH:1]      sync2;
    logic [NCH:1]      filt;
    logic [FILT_W-1:0] cnt [1:NCH];

    logic              src;
    logic              prev;
    logic [3:0]        sel_q;
    logic              level_q;
    logic              trig_q;
    logic              trig_d;
    logic              evt_load;
    logic [ECNT_W-1:0] evt_cnt;
    edge_mode_t        mode;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.input_i;
            sync2 <= sync1;
        end
    end

    // filt_len_i is compared live, so a shortened length can let cnt wrap.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filt <= '0;
            for (int unsigned n = 1; n <= NCH; n++) cnt[n] <= '0;
        end else if (bus.clear_i) begin
            for (int unsigned n = 1; n <= NCH; n++) cnt[n] <= '0;
        end else if (bus.en_i) begin
            for (int unsigned n = 1; n <= NCH; n++) begin
                if (sync2[n] == filt[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] == bus.filt_len_i) begin
                    filt[n] <= sync2[n];
                    cnt[n]  <= '0;
                end else begin
                    cnt[n] <= cnt[n] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        src = 1'b0;
        if (bus.ch_sel_i == '0)
            src = bus.sw_trigger_i;
        else if (int'(bus.ch_sel_i) <= NCH)
            src = filt[bus.ch_sel_i];
    end

    // A mux switch is masked for one cycle so the new source cannot look like an edge.
    always_comb begin
        mode     = edge_mode_t'(bus.edge_sel_i);
        trig_d   = 1'b0;
        evt_load = 1'b0;
        if (!bus.clear_i && bus.en_i) begin
            unique case (mode)
                EDGE_RISE:  trig_d = src & ~prev;
                EDGE_FALL:  trig_d = ~src & prev;
                EDGE_BOTH:  trig_d = src ^ prev;
                LEVEL_HIGH: trig_d = src;
            endcase
            if (mode != LEVEL_HIGH) begin
                if (bus.ch_sel_i != sel_q) trig_d = 1'b0;
                evt_load = trig_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev    <= 1'b0;
            sel_q   <= '0;
            level_q <= 1'b0;
            trig_q  <= 1'b0;
            evt_cnt <= '0;
        end else begin
            prev    <= src;
            sel_q   <= bus.ch_sel_i;
            level_q <= src;
            trig_q  <= trig_d;
            if (bus.clear_i)
                evt_cnt <= '0;
            else if (evt_load && evt_cnt != '1)
                evt_cnt <= evt_cnt + 1'b1;
        end
    end

    assign bus.filt_o    = filt;
    assign bus.level_o   = level_q;
    assign bus.trig_o    = trig_q;
    assign bus.evt_cnt_o = evt_cnt;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with hand-derived expectations.
module tb_input_conditioner;
    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   pulses;

    input_conditioner_if #(.NCH(15), .FILT_W(4), .ECNT_W(8)) bus ();

    input_conditioner #(.NCH(15), .FILT_W(4), .ECNT_W(8)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstn             = 1'b0;
        bus.en_i         = 1'b1;
        bus.clear_i      = 1'b0;
        bus.input_i      = '0;
        bus.filt_len_i   = 4'd3;
        bus.ch_sel_i     = 4'd5;
        bus.edge_sel_i   = 2'b00;
        bus.sw_trigger_i = 1'b0;
        #23 rstn = 1'b1;
        tick();
        check("rst_filt", 32'(bus.filt_o), 0);
        check("rst_level", 32'(bus.level_o), 0);
        check("rst_trig", 32'(bus.trig_o), 0);
        check("rst_evt", 32'(bus.evt_cnt_o), 0);

        // channel 5 rise: filt after 6 edges, trig on the 7th
        bus.input_i[5] = 1'b1;
        tick(5);
        check("ch5_filt_early", 32'(bus.filt_o[5]), 0);
        tick();
        check("ch5_filt", 32'(bus.filt_o[5]), 1);
        check("ch5_trig_before", 32'(bus.trig_o), 0);
        tick();
        check("ch5_trig", 32'(bus.trig_o), 1);
        check("ch5_level", 32'(bus.level_o), 1);
        tick();
        check("ch5_trig_end", 32'(bus.trig_o), 0);
        check("ch5_evt", 32'(bus.evt_cnt_o), 1);

        // glitch rejection on channel 2
        bus.input_i[2] = 1'b1;
        tick(3);
        bus.input_i[2] = 1'b0;
        tick(10);
        check("glitch3", 32'(bus.filt_o[2]), 0);
        bus.input_i[2] = 1'b1;
        tick(4);
        bus.input_i[2] = 1'b0;
        tick();
        check("pulse4_early", 32'(bus.filt_o[2]), 0);
        tick();
        check("pulse4_set", 32'(bus.filt_o[2]), 1);
        tick(3);
        check("pulse4_hold", 32'(bus.filt_o[2]), 1);
        tick();
        check("pulse4_clr", 32'(bus.filt_o[2]), 0);

        // software trigger, both edges
        bus.ch_sel_i   = 4'd0;
        bus.edge_sel_i = 2'b10;
        tick(2);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        check("clear_evt", 32'(bus.evt_cnt_o), 0);
        for (int t = 0; t < 4; t++) begin
            bus.sw_trigger_i = ~bus.sw_trigger_i;
            pulses = 0;
            tick();
            check("sw_trig_first", 32'(bus.trig_o), 1);
            for (int c = 0; c < 10; c++) begin
                if (bus.trig_o) pulses++;
                tick();
            end
            check("sw_pulse_cnt", 32'(pulses), 1);
        end
        check("sw_evt4", 32'(bus.evt_cnt_o), 4);
        bus.edge_sel_i   = 2'b11;
        bus.sw_trigger_i = 1'b1;
        tick();
        check("lvl_trig", 32'(bus.trig_o), 1);
        tick(5);
        check("lvl_trig_held", 32'(bus.trig_o), 1);
        check("lvl_evt_hold", 32'(bus.evt_cnt_o), 4);

        // mux switch 2 -> 1 with channel 1 high must not fire
        bus.edge_sel_i   = 2'b00;
        bus.sw_trigger_i = 1'b0;
        bus.input_i[1]   = 1'b1;
        bus.ch_sel_i     = 4'd2;
        tick(10);
        check("ch1_filt", 32'(bus.filt_o[1]), 1);
        bus.ch_sel_i = 4'd1;
        tick();
        check("sw_guard_trig", 32'(bus.trig_o), 0);
        check("sw_guard_level", 32'(bus.level_o), 1);
        tick();
        check("sw_guard_trig2", 32'(bus.trig_o), 0);
        check("sw_guard_evt", 32'(bus.evt_cnt_o), 4);

        // enable low suppresses; re-enable gives no stale edge
        bus.ch_sel_i = 4'd0;
        tick(2);
        bus.en_i         = 1'b0;
        bus.sw_trigger_i = 1'b1;
        tick();
        check("dis_trig", 32'(bus.trig_o), 0);
        bus.en_i = 1'b1;
        tick();
        check("reen_trig", 32'(bus.trig_o), 0);
        check("reen_evt", 32'(bus.evt_cnt_o), 4);
        bus.sw_trigger_i = 1'b0;
        tick(2);

        // saturation at 255, then clear drops a coinciding event
        for (int i = 0; i < 300; i++) begin
            bus.sw_trigger_i = 1'b1;
            tick();
            bus.sw_trigger_i = 1'b0;
            tick();
        end
        check("sat_evt", 32'(bus.evt_cnt_o), 255);
        bus.clear_i      = 1'b1;
        bus.sw_trigger_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        check("clr_evt", 32'(bus.evt_cnt_o), 0);
        check("clr_trig", 32'(bus.trig_o), 0);
        tick();
        check("clr_no_late", 32'(bus.trig_o), 0);

        // async reset in the middle of a filter count on channel 3
        bus.sw_trigger_i = 1'b0;
        bus.ch_sel_i     = 4'd3;
        tick(2);
        bus.input_i[3] = 1'b1;
        tick(4);
        #2 rstn = 1'b0;
        #1;
        check("arst_filt", 32'(bus.filt_o), 0);
        check("arst_level", 32'(bus.level_o), 0);
        check("arst_trig", 32'(bus.trig_o), 0);
        check("arst_evt", 32'(bus.evt_cnt_o), 0);
        #2 rstn = 1'b1;
        tick(5);
        check("requal_early", 32'(bus.filt_o[3]), 0);
        tick();
        check("requal_filt", 32'(bus.filt_o[3]), 1);
        tick();
        check("requal_trig", 32'(bus.trig_o), 1);
        tick();
        check("requal_evt", 32'(bus.evt_cnt_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
